hazard_forward_ctrl: RTL and testbench
======================================

Name: hazard_forward_ctrl

Overview:
- Parametrised successor to the two-source EX-stage forwarding unit.
- Generates operand-forward selects, detects load-use hazards, and owns pipeline stall/bubble control.
- Supports multi-cycle load stalls and whole-pipe freeze on memory busy.
- Sits between the ID/EX pipeline registers and the PC/IF/ID/EX/MEM/WB register enables; includes a saturating stall-cycle counter.

Parameters:
- ADDR_W, 5, register-index width.
- ZERO_REG_HARD, 1, when 1 register 0 is hardwired: destination index 0 never forwards and never causes a hazard.
- LOAD_STALL_CYC, 1, bubbles inserted per load-use hazard; legal range 1..15.
- CNT_W, 16, width of the stall-cycle performance counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_id_rs, if_id_rt  in  ADDR_W  source registers of the instruction in ID.
- id_ex_rs, id_ex_rt  in  ADDR_W  source registers of the instruction in EX.
- id_ex_rd  in  ADDR_W  destination of the instruction in EX.
- id_ex_memread  in  1  instruction in EX is a load.
- ex_mem_rd  in  ADDR_W  EX/MEM destination.
- ex_mem_regwrite  in  1  EX/MEM writes the register file.
- mem_wb_rd  in  ADDR_W  MEM/WB destination.
- mem_wb_regwrite  in  1  MEM/WB writes the register file.
- mem_busy  in  1  data memory not ready; freeze whole pipe.
- cnt_clr  in  1  synchronous clear of stall_cycles.
- forwardA, forwardB  out  2  operand select: 00 register file, 10 EX/MEM, 01 MEM/WB.
- stall_pc  out  1  hold PC.
- stall_ifid  out  1  hold IF/ID.
- bubble_idex  out  1  load NOP into ID/EX.
- freeze  out  1  hold EX/MEM and MEM/WB; this is the mem_busy echo.
- stall_cycles  out  CNT_W  saturating count of cycles with stall_pc=1.

Behaviour:

Forwarding (combinational, zero latency):
- Define exm_ok = ex_mem_regwrite & !(ZERO_REG_HARD & ex_mem_rd==0). Define wb_ok the same way from the MEM/WB signals.
- forwardA = 10 if exm_ok & ex_mem_rd==id_ex_rs; else 01 if wb_ok & mem_wb_rd==id_ex_rs; else 00. forwardB is identical using id_ex_rt.
- EX/MEM always has priority over MEM/WB.
- EX/MEM forwarding does not depend on mem_wb_regwrite; this removes the old coupling.
- Code 11 is never produced.

Hazard detection:
- hz = id_ex_memread & !(ZERO_REG_HARD & id_ex_rd==0) & (id_ex_rd==if_id_rs | id_ex_rd==if_id_rt).

FSM states: IDLE, LOAD_STALL. A 4-bit down-counter cnt is used in LOAD_STALL.
- IDLE with hz=1 and mem_busy=0:
  - stall_pc = stall_ifid = bubble_idex = 1 this cycle (Mealy).
  - If LOAD_STALL_CYC>1: next state LOAD_STALL, cnt <= LOAD_STALL_CYC-2.
  - Otherwise stay in IDLE.
- LOAD_STALL:
  - stall_pc = stall_ifid = bubble_idex = 1.
  - If cnt==0, next state IDLE; else cnt <= cnt-1.
  - hz is ignored in this state, since ID/EX holds a bubble.
- mem_busy=1 (any state):
  - freeze = stall_pc = stall_ifid = 1 and bubble_idex = 0.
  - State and cnt hold.
  - hz is not acted on until mem_busy falls.
- Total bubbles per hazard equals LOAD_STALL_CYC exactly, independent of interleaved mem_busy cycles.

stall_cycles:
- Increments each cycle with stall_pc=1; saturates at all-ones.
- cnt_clr=1 loads 0 and takes priority over increment.

Reset:
- Asynchronous: state=IDLE, cnt=0, stall_cycles=0.
- All stall/bubble outputs deassert immediately; if rst_n is asserted mid-stall, the stall is dropped.
- forwardA/B remain purely combinational through reset.

Test Plan:
1. Forward priority:
   - id_ex_rs=5, ex_mem_rd=5/regwrite=1, mem_wb_rd=5/regwrite=1 -> forwardA=10.
   - Drop ex_mem_regwrite -> 01.
   - ex_mem_regwrite=1 with mem_wb_regwrite=0 -> 10.
   - id_ex_rt=9 with no match -> forwardB=00.
2. Zero register: ZERO_REG_HARD=1, ex_mem_rd=0 and id_ex_rs=0, regwrite=1 -> forwardA=00. A load with id_ex_rd=0 matching if_id_rs=0 -> no stall.
3. Load-use, LOAD_STALL_CYC=2: cycle N id_ex_memread=1, id_ex_rd=7, if_id_rt=7 (ID/EX cleared at N+1) -> stall_pc/stall_ifid/bubble_idex high at N and N+1, low at N+2; stall_cycles=2.
4. mem_busy during LOAD_STALL: LOAD_STALL_CYC=3, mem_busy=1 for 3 cycles starting N+1 -> freeze=1 and bubble_idex=0 for those cycles; bubbles total exactly 3; stall_cycles=6.
5. Reset mid-stall: rst_n low asynchronously during LOAD_STALL -> stall outputs drop before the next clk edge; after release state is IDLE and stall_cycles=0.
6. Counter saturation: CNT_W=4, 20 stall cycles -> stall_cycles=15 and holds; cnt_clr on a stall cycle -> 0 next edge, then increments.

Source files
------------

// File: rtl/hazard_forward_ctrl_if.sv
// Handshake bundle between the pipeline registers and hazard_forward_ctrl.
// master = pipeline side (drives indices/strobes), slave = control unit.
interface hazard_forward_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
);
    logic [ADDR_W-1:0] if_id_rs;
    logic [ADDR_W-1:0] if_id_rt;
    logic [ADDR_W-1:0] id_ex_rs;
    logic [ADDR_W-1:0] id_ex_rt;
    logic [ADDR_W-1:0] id_ex_rd;
    logic              id_ex_memread;
    logic [ADDR_W-1:0] ex_mem_rd;
    logic              ex_mem_regwrite;
    logic [ADDR_W-1:0] mem_wb_rd;
    logic              mem_wb_regwrite;
    logic              mem_busy;
    logic              cnt_clr;
    logic [1:0]        forwardA;
    logic [1:0]        forwardB;
    logic              stall_pc;
    logic              stall_ifid;
    logic              bubble_idex;
    logic              freeze;
    logic [CNT_W-1:0]  stall_cycles;

    modport master (
        output if_id_rs, if_id_rt, id_ex_rs, id_ex_rt,
        output id_ex_rd, id_ex_memread,
        output ex_mem_rd, ex_mem_regwrite,
        output mem_wb_rd, mem_wb_regwrite,
        output mem_busy, cnt_clr,
        input  forwardA, forwardB,
        input  stall_pc, stall_ifid, bubble_idex,
        input  freeze, stall_cycles
    );

    modport slave (
        input  if_id_rs, if_id_rt, id_ex_rs, id_ex_rt,
        input  id_ex_rd, id_ex_memread,
        input  ex_mem_rd, ex_mem_regwrite,
        input  mem_wb_rd, mem_wb_regwrite,
        input  mem_busy, cnt_clr,
        output forwardA, forwardB,
        output stall_pc, stall_ifid, bubble_idex,
        output freeze, stall_cycles
    );
endinterface

// File: rtl/hazard_forward_ctrl.sv
// EX-stage forwarding, load-use hazard stall and memory-busy freeze control.
// Ports: clk, rst_n (async low), bus (slave side of hazard_forward_ctrl_if).
module hazard_forward_ctrl #(
    parameter int ADDR_W         = 5,
    parameter int ZERO_REG_HARD  = 1,
    parameter int LOAD_STALL_CYC = 1,
    parameter int CNT_W          = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hazard_forward_ctrl_if.slave  bus
);
    typedef enum logic {IDLE, LOAD_STALL} state_t;

    localparam bit       ZR     = (ZERO_REG_HARD != 0);
    localparam bit       MULTI  = (LOAD_STALL_CYC > 1);
    localparam int       INIT_I = MULTI ? LOAD_STALL_CYC - 2 : 0;
    localparam logic [3:0] CNT_INIT = INIT_I[3:0];
    localparam logic [ADDR_W-1:0] R0 = '0;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] sc_q;
    logic             exm_ok, wb_ok, hz;
    logic             stall, bubble, frz;

    assign exm_ok = bus.ex_mem_regwrite & ~(ZR & (bus.ex_mem_rd == R0));
    assign wb_ok  = bus.mem_wb_regwrite & ~(ZR & (bus.mem_wb_rd == R0));

    always_comb begin
        bus.forwardA = 2'b00;
        if (exm_ok && bus.ex_mem_rd == bus.id_ex_rs)
            bus.forwardA = 2'b10;
        else if (wb_ok && bus.mem_wb_rd == bus.id_ex_rs)
            bus.forwardA = 2'b01;
    end

    always_comb begin
        bus.forwardB = 2'b00;
        if (exm_ok && bus.ex_mem_rd == bus.id_ex_rt)
            bus.forwardB = 2'b10;
        else if (wb_ok && bus.mem_wb_rd == bus.id_ex_rt)
            bus.forwardB = 2'b01;
    end

    assign hz = bus.id_ex_memread
              & ~(ZR & (bus.id_ex_rd == R0))
              & ((bus.id_ex_rd == bus.if_id_rs)
               | (bus.id_ex_rd == bus.if_id_rt));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // mem_busy overrides everything: state and cnt hold, so the
    // number of bubbles per hazard is unaffected by freezes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        bubble  = 1'b0;
        frz     = 1'b0;
        if (bus.mem_busy) begin
            frz   = 1'b1;
            stall = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (hz) begin
                        stall  = 1'b1;
                        bubble = 1'b1;
                        if (MULTI) begin
                            state_d = LOAD_STALL;
                            cnt_d   = CNT_INIT;
                        end
                    end
                end
                LOAD_STALL: begin
                    stall  = 1'b1;
                    bubble = 1'b1;
                    if (cnt_q == 4'd0)
                        state_d = IDLE;
                    else
                        cnt_d = cnt_q - 4'd1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Gated by rst_n so a stall is dropped the moment reset asserts.
    assign bus.stall_pc    = stall & rst_n;
    assign bus.stall_ifid  = stall & rst_n;
    assign bus.bubble_idex = bubble & rst_n;
    assign bus.freeze      = frz & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sc_q <= '0;
        else if (bus.cnt_clr)
            sc_q <= '0;
        else if (bus.stall_pc && sc_q != '1)
            sc_q <= sc_q + 1'b1;
    end

    assign bus.stall_cycles = sc_q;
endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Bench for hazard_forward_ctrl: three configurations driven in lockstep
// and compared with a bubble-count reference model.
module tb_hazard_forward_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [4:0] ifrs, ifrt, exrs, exrt, exrd, emrd, wbrd;
    logic       memrd, emrw, wbrw, busy, clr;

    hazard_forward_ctrl_if #(.ADDR_W(5), .CNT_W(16)) b0 ();
    hazard_forward_ctrl_if #(.ADDR_W(5), .CNT_W(16)) b1 ();
    hazard_forward_ctrl_if #(.ADDR_W(5), .CNT_W(4))  b2 ();

    assign b0.if_id_rs = ifrs; assign b0.if_id_rt = ifrt;
    assign b0.id_ex_rs = exrs; assign b0.id_ex_rt = exrt;
    assign b0.id_ex_rd = exrd; assign b0.id_ex_memread = memrd;
    assign b0.ex_mem_rd = emrd; assign b0.ex_mem_regwrite = emrw;
    assign b0.mem_wb_rd = wbrd; assign b0.mem_wb_regwrite = wbrw;
    assign b0.mem_busy = busy; assign b0.cnt_clr = clr;

    assign b1.if_id_rs = ifrs; assign b1.if_id_rt = ifrt;
    assign b1.id_ex_rs = exrs; assign b1.id_ex_rt = exrt;
    assign b1.id_ex_rd = exrd; assign b1.id_ex_memread = memrd;
    assign b1.ex_mem_rd = emrd; assign b1.ex_mem_regwrite = emrw;
    assign b1.mem_wb_rd = wbrd; assign b1.mem_wb_regwrite = wbrw;
    assign b1.mem_busy = busy; assign b1.cnt_clr = clr;

    assign b2.if_id_rs = ifrs; assign b2.if_id_rt = ifrt;
    assign b2.id_ex_rs = exrs; assign b2.id_ex_rt = exrt;
    assign b2.id_ex_rd = exrd; assign b2.id_ex_memread = memrd;
    assign b2.ex_mem_rd = emrd; assign b2.ex_mem_regwrite = emrw;
    assign b2.mem_wb_rd = wbrd; assign b2.mem_wb_regwrite = wbrw;
    assign b2.mem_busy = busy; assign b2.cnt_clr = clr;

    hazard_forward_ctrl #(.ADDR_W(5), .ZERO_REG_HARD(1),
        .LOAD_STALL_CYC(2), .CNT_W(16))
        u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    hazard_forward_ctrl #(.ADDR_W(5), .ZERO_REG_HARD(1),
        .LOAD_STALL_CYC(3), .CNT_W(16))
        u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    hazard_forward_ctrl #(.ADDR_W(5), .ZERO_REG_HARD(1),
        .LOAD_STALL_CYC(1), .CNT_W(4))
        u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

    logic [1:0]  fa [3];
    logic [1:0]  fb [3];
    logic        sp [3];
    logic        si [3];
    logic        bi [3];
    logic        fr [3];
    logic [15:0] sc [3];

    assign fa[0] = b0.forwardA; assign fb[0] = b0.forwardB;
    assign fa[1] = b1.forwardA; assign fb[1] = b1.forwardB;
    assign fa[2] = b2.forwardA; assign fb[2] = b2.forwardB;
    assign sp[0] = b0.stall_pc; assign si[0] = b0.stall_ifid;
    assign sp[1] = b1.stall_pc; assign si[1] = b1.stall_ifid;
    assign sp[2] = b2.stall_pc; assign si[2] = b2.stall_ifid;
    assign bi[0] = b0.bubble_idex; assign fr[0] = b0.freeze;
    assign bi[1] = b1.bubble_idex; assign fr[1] = b1.freeze;
    assign bi[2] = b2.bubble_idex; assign fr[2] = b2.freeze;
    assign sc[0] = b0.stall_cycles;
    assign sc[1] = b1.stall_cycles;
    assign sc[2] = {12'd0, b2.stall_cycles};

    // Reference model: bubbles still owed per hazard, plus counter.
    int lsc  [3] = '{2, 3, 1};
    int cmax [3] = '{65535, 65535, 15};
    int rem  [3];
    int cnt  [3];

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] fwd_exp(input logic [4:0] src);
        if (emrw && emrd != 0 && emrd == src) return 2'b10;
        if (wbrw && wbrd != 0 && wbrd == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit hz_exp();
        return memrd && exrd != 0 && (exrd == ifrs || exrd == ifrt);
    endfunction

    function automatic bit stall_exp(input int i);
        return busy || rem[i] > 0 || hz_exp();
    endfunction

    function automatic bit bubble_exp(input int i);
        return !busy && (rem[i] > 0 || hz_exp());
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            rem[i] = 0;
            cnt[i] = 0;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("d%0d fwdA", i), 16'(fa[i]), 16'(fwd_exp(exrs)));
            chk($sformatf("d%0d fwdB", i), 16'(fb[i]), 16'(fwd_exp(exrt)));
            chk($sformatf("d%0d stall_pc", i), 16'(sp[i]), 16'(stall_exp(i)));
            chk($sformatf("d%0d stall_ifid", i), 16'(si[i]), 16'(stall_exp(i)));
            chk($sformatf("d%0d bubble", i), 16'(bi[i]), 16'(bubble_exp(i)));
            chk($sformatf("d%0d freeze", i), 16'(fr[i]), 16'(busy));
            chk($sformatf("d%0d stall_cycles", i), sc[i], 16'(cnt[i]));
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            bit st;
            st = stall_exp(i);
            if (clr) cnt[i] = 0;
            else if (st && cnt[i] < cmax[i]) cnt[i] = cnt[i] + 1;
            if (!busy) begin
                if (rem[i] > 0) rem[i] = rem[i] - 1;
                else if (hz_exp()) rem[i] = lsc[i] - 1;
            end
        end
    endtask

    // Inputs are set just after a negedge; compare, clock, advance model.
    task automatic cyc();
        #1;
        check_all();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_in();
        ifrs = 0; ifrt = 0; exrs = 0; exrt = 0; exrd = 0;
        emrd = 0; wbrd = 0; memrd = 0; emrw = 0; wbrw = 0;
        busy = 0; clr = 0;
    endtask

    initial begin
        idle_in();
        model_reset();
        @(negedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Forward priority
        exrs = 5; emrd = 5; emrw = 1; wbrd = 5; wbrw = 1; exrt = 9;
        #1; chk("prio_exmem", 16'(fa[0]), 16'h2);
        chk("fwdB_nomatch", 16'(fb[0]), 16'h0);
        cyc();
        emrw = 0;
        #1; chk("prio_wb", 16'(fa[0]), 16'h1);
        cyc();
        emrw = 1; wbrw = 0;
        #1; chk("exmem_no_wb", 16'(fa[0]), 16'h2);
        cyc();

        // Zero register
        idle_in();
        emrd = 0; exrs = 0; emrw = 1;
        #1; chk("zero_fwd", 16'(fa[0]), 16'h0);
        cyc();
        memrd = 1; exrd = 0; ifrs = 0;
        #1; chk("zero_hz", 16'(sp[0]), 16'h0);
        cyc();

        // Load-use, 2/3/1 bubbles depending on instance
        idle_in();
        clr = 1; cyc(); clr = 0;
        memrd = 1; exrd = 7; ifrt = 7;
        cyc();
        idle_in();
        repeat (4) cyc();
        chk("loaduse_cnt2", sc[0], 16'd2);
        chk("loaduse_cnt3", sc[1], 16'd3);

        // mem_busy inside LOAD_STALL
        clr = 1; cyc(); clr = 0;
        memrd = 1; exrd = 7; ifrt = 7;
        cyc();
        idle_in();
        busy = 1;
        repeat (3) cyc();
        busy = 0;
        repeat (4) cyc();
        chk("busy_cnt6", sc[1], 16'd6);

        // Reset mid-stall
        memrd = 1; exrd = 3; ifrs = 3;
        cyc();
        idle_in();
        #1;
        check_all();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("d%0d rst_stall", i), 16'(sp[i]), 16'h0);
            chk($sformatf("d%0d rst_bubble", i), 16'(bi[i]), 16'h0);
            chk($sformatf("d%0d rst_cnt", i), sc[i], 16'h0);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) cyc();

        // Saturation on the 4-bit counter
        busy = 1;
        repeat (20) cyc();
        chk("sat15", sc[2], 16'd15);
        clr = 1; cyc(); clr = 0;
        chk("clr_zero", sc[2], 16'd0);
        cyc();
        chk("clr_incr", sc[2], 16'd1);
        busy = 0;
        cyc();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            ifrs  = 5'($urandom_range(0, 7));
            ifrt  = 5'($urandom_range(0, 7));
            exrs  = 5'($urandom_range(0, 7));
            exrt  = 5'($urandom_range(0, 7));
            exrd  = 5'($urandom_range(0, 7));
            emrd  = 5'($urandom_range(0, 7));
            wbrd  = 5'($urandom_range(0, 7));
            memrd = ($urandom_range(0, 2) == 0);
            emrw  = $urandom_range(0, 1) == 1;
            wbrw  = $urandom_range(0, 1) == 1;
            busy  = ($urandom_range(0, 5) == 0);
            clr   = ($urandom_range(0, 19) == 0);
            cyc();
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
